mem_stage_nb: RTL

Non-blocking memory stage that replaces the single-cycle SRAM memory stage.
- Issues loads and stores to a split-handshake data bus (req/addr_ok, then data_ok/rdata).
- Tracks up to MAX_OUTST in-order outstanding accesses.
- Aligns and extends returned load data.
- Delivers results to WB over a valid/ready handshake, and provides forwarding and load-busy information to EX.

---
 rtl/mem_pkg.sv | 54 +++++
 rtl/mem_stage_nb_align.sv | 34 +++
 rtl/mem_stage_nb.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared memory-stage encodings: mem_op codes, bus size codes and FIFO entry control fields.
package mem_pkg;

  typedef enum logic [3:0] {
    NONE  = 4'd0,
    LD_B  = 4'd1,
    LD_H  = 4'd2,
    LD_W  = 4'd3,
    LD_BU = 4'd4,
    LD_HU = 4'd5,
    LD_WU = 4'd6,
    LD_D  = 4'd7,
    ST_B  = 4'd8,
    ST_H  = 4'd9,
    ST_W  = 4'd10,
    ST_D  = 4'd11,
    LL_W  = 4'd12,
    SC_W  = 4'd13
  } mem_op_e;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  localparam int OFF_W  = 3;
  localparam int DEST_W = 5;

  typedef struct packed {
    mem_op_e             op;
    logic [OFF_W-1:0]    off;
    logic [DEST_W-1:0]   dest;
    logic                reg_we;
    logic                done;
  } ent_ctl_t;

  function automatic logic is_store(input mem_op_e op);
    return op inside {ST_B, ST_H, ST_W, ST_D, SC_W};
  endfunction

  function automatic logic is_load(input mem_op_e op);
    return op inside {LD_B, LD_H, LD_W, LD_BU, LD_HU, LD_WU, LD_D, LL_W};
  endfunction

  function automatic logic [1:0] op_size(input mem_op_e op);
    case (op)
      LD_H, LD_HU, ST_H:             return SZ_H;
      LD_W, LD_WU, ST_W, LL_W, SC_W: return SZ_W;
      LD_D, ST_D:                    return SZ_D;
      default:                       return SZ_B;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_nb_align.sv
// mem_load_align: combinational load lane select plus sign/zero extension; misaligned requests yield 0.
module mem_load_align
  import mem_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [3:0]        op,
  input  logic [2:0]        off,
  input  logic [DATA_W-1:0] rdata,
  output logic [DATA_W-1:0] result
);

  mem_op_e           op_e;
  logic [2:0]        off_eff;
  logic [DATA_W-1:0] sh;

  always_comb begin
    op_e    = mem_op_e'(op);
    off_eff = (DATA_W == 64) ? off : {1'b0, off[1:0]};
    sh      = rdata >> {off_eff, 3'b000};
    result  = '0;
    case (op_e)
      LD_B:       result = DATA_W'($signed(sh[7:0]));
      LD_BU:      result = DATA_W'(sh[7:0]);
      LD_H:       if (!off_eff[0]) result = DATA_W'($signed(sh[15:0]));
      LD_HU:      if (!off_eff[0]) result = DATA_W'(sh[15:0]);
      LD_W, LL_W: if (off_eff[1:0] == 2'b00) result = DATA_W'($signed(sh[31:0]));
      LD_WU:      if (off_eff[1:0] == 2'b00) result = DATA_W'(sh[31:0]);
      LD_D:       if (off_eff == 3'b000) result = rdata;
      default:    result = '0;
    endcase
  end

endmodule

// File: rtl/mem_stage_nb.sv
// Non-blocking memory stage: in-order FIFO of up to MAX_OUTST bus accesses; MEM_STAGE_LLBIT_EN adds ll/sc llbit.
// Result appears the cycle after data_ok; requests stall when FIFO plus drain count is full, WB stalls via ms_ready.
module mem_stage_nb
  import mem_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int MAX_OUTST = 2,
  parameter int PC_W      = 32
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                flush,
  input  logic                es_valid,
  output logic                es_ready,
  input  logic [3:0]          es_op,
  input  logic [31:0]         es_addr,
  input  logic [DATA_W-1:0]   es_wdata,
  input  logic [4:0]          es_dest,
  input  logic [PC_W-1:0]     es_pc,
  output logic                data_req,
  output logic                data_wr,
  output logic [1:0]          data_size,
  output logic [DATA_W/8-1:0] data_wstrb,
  output logic [31:0]         data_addr,
  output logic [DATA_W-1:0]   data_wdata,
  input  logic                data_addr_ok,
  input  logic                data_data_ok,
  input  logic [DATA_W-1:0]   data_rdata,
  output logic                ms_valid,
  input  logic                ms_ready,
  output logic                ms_reg_we,
  output logic [4:0]          ms_dest,
  output logic [DATA_W-1:0]   ms_result,
  output logic [PC_W-1:0]     ms_pc,
  output logic                ms_load_busy,
  output logic [31:0]         ms_busy_dest
);

  localparam int STRB_W = DATA_W / 8;
  localparam int PTR_W  = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam int CNT_W  = $clog2(MAX_OUTST + 1);
  localparam logic [CNT_W:0] MAX_CNT = (CNT_W + 1)'(MAX_OUTST);
  localparam logic [PTR_W:0] MAX_PTR = (PTR_W + 1)'(MAX_OUTST);

  ent_ctl_t          ctl_q [MAX_OUTST];
  ent_ctl_t          ctl_d [MAX_OUTST];
  logic [DATA_W-1:0] res_q [MAX_OUTST];
  logic [DATA_W-1:0] res_d [MAX_OUTST];
  logic [PC_W-1:0]   pc_q  [MAX_OUTST];
  logic [PC_W-1:0]   pc_d  [MAX_OUTST];
  logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, drain_q, drain_d;
`ifdef MEM_STAGE_LLBIT_EN
  logic              llbit_q, llbit_d;
`endif

  mem_op_e           op_e, fill_op_e;
  logic [2:0]        off;
  logic [1:0]        sz;
  logic              st, ld, misal, room, can_issue, sc_fail, push, pop;
  logic [STRB_W-1:0] strb_base;
  logic [PTR_W:0]    slot;
  logic [PTR_W-1:0]  fill_idx;
  logic              fill_vld, drop, do_fill;
  logic [CNT_W-1:0]  nd_cnt;
  logic [DATA_W-1:0] align_res, fill_res;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (({1'b0, p} + (PTR_W + 1)'(1)) == MAX_PTR) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    op_e      = mem_op_e'(es_op);
    off       = (DATA_W == 64) ? es_addr[2:0] : {1'b0, es_addr[1:0]};
    st        = is_store(op_e);
    ld        = is_load(op_e);
    sz        = op_size(op_e);
    misal     = (sz == SZ_H && off[0]) || (sz == SZ_W && off[1:0] != 2'b00) ||
                (sz == SZ_D && off != 3'b000);
    case (sz)
      SZ_B:    strb_base = STRB_W'(1);
      SZ_H:    strb_base = STRB_W'(3);
      SZ_W:    strb_base = STRB_W'(15);
      default: strb_base = '1;
    endcase
    room      = ({1'b0, cnt_q} + {1'b0, drain_q}) < MAX_CNT;
    can_issue = es_valid && !flush && room;
`ifdef MEM_STAGE_LLBIT_EN
    sc_fail   = (op_e == SC_W) && !llbit_q;
`else
    sc_fail   = 1'b0;
`endif
    data_req   = can_issue && !sc_fail;
    // A failing sc.w never touches the bus, so it is accepted without addr_ok.
    es_ready   = sc_fail ? can_issue : (data_req && data_addr_ok);
    data_wr    = data_req && st;
    data_size  = data_req ? sz : 2'b00;
    data_addr  = data_req ? es_addr : 32'h0;
    data_wstrb = (data_req && st && !misal) ? (strb_base << off) : '0;
    data_wdata = '0;
    if (data_req && st) begin
      for (int i = 0; i < STRB_W; i++) begin
        case (sz)
          SZ_B:    data_wdata[i*8 +: 8] = es_wdata[7:0];
          SZ_H:    data_wdata[i*8 +: 8] = es_wdata[(i%2)*8 +: 8];
          SZ_W:    data_wdata[i*8 +: 8] = es_wdata[(i%4)*8 +: 8];
          default: data_wdata[i*8 +: 8] = es_wdata[i*8 +: 8];
        endcase
      end
    end
  end

  // Scan from the head: oldest not-done entry, outstanding count and load scoreboard.
  always_comb begin
    fill_vld     = 1'b0;
    fill_idx     = '0;
    nd_cnt       = '0;
    slot         = '0;
    ms_load_busy = 1'b0;
    ms_busy_dest = '0;
    for (int i = 0; i < MAX_OUTST; i++) begin
      slot = {1'b0, head_q} + (PTR_W + 1)'(i);
      if (slot >= MAX_PTR) slot = slot - MAX_PTR;
      if (CNT_W'(i) < cnt_q && !ctl_q[slot[PTR_W-1:0]].done) begin
        nd_cnt = nd_cnt + 1'b1;
        if (!fill_vld) begin
          fill_vld = 1'b1;
          fill_idx = slot[PTR_W-1:0];
        end
        if (ctl_q[slot[PTR_W-1:0]].reg_we) begin
          ms_load_busy = 1'b1;
          ms_busy_dest = ms_busy_dest | (32'(1) << ctl_q[slot[PTR_W-1:0]].dest);
        end
      end
    end
  end

  mem_load_align #(.DATA_W(DATA_W)) u_align (
    .op     (ctl_q[fill_idx].op),
    .off    (ctl_q[fill_idx].off),
    .rdata  (data_rdata),
    .result (align_res)
  );

  assign fill_op_e = ctl_q[fill_idx].op;
  assign fill_res  = (fill_op_e == SC_W) ? DATA_W'(1) : (is_store(fill_op_e) ? '0 : align_res);

  assign ms_valid  = (cnt_q != '0) && ctl_q[head_q].done;
  assign ms_reg_we = ms_valid && ctl_q[head_q].reg_we;
  assign ms_dest   = ms_valid ? ctl_q[head_q].dest : 5'd0;
  assign ms_result = ms_valid ? res_q[head_q] : '0;
  assign ms_pc     = ms_valid ? pc_q[head_q] : '0;
  assign push      = es_valid && es_ready;
  assign pop       = ms_valid && ms_ready;

  always_comb begin
    ctl_d   = ctl_q;
    res_d   = res_q;
    pc_d    = pc_q;
    head_d  = head_q;
    tail_d  = tail_q;
`ifdef MEM_STAGE_LLBIT_EN
    llbit_d = llbit_q;
`endif
    drop    = data_data_ok && (drain_q != '0);
    do_fill = data_data_ok && (drain_q == '0) && fill_vld;
    if (do_fill) begin
      ctl_d[fill_idx].done = 1'b1;
      res_d[fill_idx]      = fill_res;
`ifdef MEM_STAGE_LLBIT_EN
      if (fill_op_e == LL_W) llbit_d = 1'b1;
      else if (fill_op_e == SC_W) llbit_d = 1'b0;
`endif
    end
    if (push) begin
      ctl_d[tail_q] = '{op: op_e, off: off, dest: es_dest,
                        reg_we: ld || (op_e == SC_W), done: sc_fail};
      res_d[tail_q] = '0;
      pc_d[tail_q]  = es_pc;
      tail_d        = ptr_inc(tail_q);
    end
    if (pop) head_d = ptr_inc(head_q);
    cnt_d   = cnt_q + CNT_W'(push) - CNT_W'(pop);
    drain_d = drain_q - CNT_W'(drop);
    // Responses still owed to killed entries must be swallowed later.
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      cnt_d   = '0;
      drain_d = drain_d + nd_cnt - CNT_W'(do_fill);
`ifdef MEM_STAGE_LLBIT_EN
      llbit_d = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < MAX_OUTST; i++) begin
        ctl_q[i] <= '0;
        res_q[i] <= '0;
        pc_q[i]  <= '0;
      end
      head_q  <= '0;
      tail_q  <= '0;
      cnt_q   <= '0;
      drain_q <= '0;
`ifdef MEM_STAGE_LLBIT_EN
      llbit_q <= 1'b0;
`endif
    end else begin
      ctl_q   <= ctl_d;
      res_q   <= res_d;
      pc_q    <= pc_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      cnt_q   <= cnt_d;
      drain_q <= drain_d;
`ifdef MEM_STAGE_LLBIT_EN
      llbit_q <= llbit_d;
`endif
    end
  end

endmodule
